wave_controller: RTL and testbench

//  Game sequencer directly upstream of alien_group: owns speed, the wave reset and lives/score/level.
//  - Consumes alien_group outputs alien_hit_out, aliens_remaining and alien_reached_paddle.
//  - Consumes the player-hit flag from the alien-bullet/paddle check and the start button.
//  - Drives alien_group speed and rst inputs; score/lives/level feed the HUD.

---
 rtl/wave_controller.sv | 184 ++++++++++++++++++
 tb/tb_wave_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_controller.sv
// Game sequencer upstream of alien_group: spawns waves, tracks score/lives/level, sets alien speed.
// Optional SPEEDUP_EN adds an in-wave speed bonus as the alien count drops.
module wave_controller #(
  parameter int unsigned NUM_ALIENS   = 40,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned BASE_SPEED   = 1,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned PTS_PER_HIT  = 10,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned SCORE_W      = 16,
  localparam int unsigned CntW        = $clog2(NUM_ALIENS + 1)
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               start_btn,
  input  logic               alien_hit,
  input  logic [CntW-1:0]    aliens_remaining,
  input  logic               alien_reached,
  input  logic               player_hit,
  output logic [7:0]         speed,
  output logic               wave_rst,
  output logic               play_en,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [3:0]         level,
  output logic               game_over
);

  localparam int unsigned MaxFrames = (CLEAR_FRAMES > DEATH_FRAMES) ? CLEAR_FRAMES : DEATH_FRAMES;
  localparam int unsigned FrameW    = $clog2(MaxFrames + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StPlay,
    StDeath,
    StClear,
    StGameOver
  } state_e;

  state_e               state_q, state_d;
  logic                 spawn_q, spawn_d;
  logic [FrameW-1:0]    frame_q, frame_d;
  logic [1:0]           low_q, low_d;
  logic                 hit_prev_q, start_prev_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           lives_q, lives_d;
  logic [3:0]           level_q, level_d;
  logic [7:0]           speed_q, speed_d;
  logic [1:0]           bonus;
  logic                 kill;
  logic [SCORE_W:0]     score_sum;
  logic [8:0]           speed_sum;

`ifdef SPEEDUP_EN
  logic [1:0] bonus_q, bonus_d;

  always_comb begin
    bonus_d = bonus_q;
    if (state_q == StSpawn) begin
      bonus_d = 2'd0;
    end else if (state_q == StPlay) begin
      bonus_d = {1'b0, aliens_remaining <= CntW'(NUM_ALIENS / 2)} +
                {1'b0, aliens_remaining <= CntW'(NUM_ALIENS / 4)};
    end
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) bonus_q <= 2'd0;
    else      bonus_q <= bonus_d;
  end

  assign bonus = bonus_q;
`else
  assign bonus = 2'd0;
`endif

  assign kill      = alien_hit & ~hit_prev_q;
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(PTS_PER_HIT);
  assign speed_sum = 9'(BASE_SPEED) + {5'd0, level_q} + {7'd0, bonus};

  always_comb begin
    state_d   = state_q;
    spawn_d   = 1'b0;
    frame_d   = frame_q;
    score_d   = score_q;
    lives_d   = lives_q;
    level_d   = level_q;
    wave_rst  = 1'b0;
    play_en   = 1'b0;
    game_over = 1'b0;

    unique case (state_q)
      StIdle: begin
        wave_rst = 1'b1;
        if (start_btn) begin
          score_d = '0;
          lives_d = 4'(START_LIVES);
          level_d = 4'd0;
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        wave_rst = 1'b1;
        if (spawn_q) state_d = StPlay;
        else         spawn_d = 1'b1;
      end
      StPlay: begin
        play_en = 1'b1;
        // Kills still score on the exit cycle, so a final simultaneous kill counts.
        if (kill) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (alien_reached) begin
          lives_d = 4'd0;
          state_d = StGameOver;
        end else if (player_hit) begin
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
          frame_d = '0;
          state_d = (lives_q <= 4'd1) ? StGameOver : StDeath;
        end else if (aliens_remaining == '0 && low_q == 2'd2) begin
          frame_d = '0;
          state_d = StClear;
        end
      end
      StDeath: begin
        if (fsync) begin
          frame_d = frame_q + 1'b1;
          if (frame_q == FrameW'(DEATH_FRAMES - 1)) state_d = StSpawn;
        end
      end
      StClear: begin
        if (fsync) begin
          frame_d = frame_q + 1'b1;
          if (frame_q == FrameW'(CLEAR_FRAMES - 1)) begin
            level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
            state_d = StSpawn;
          end
        end
      end
      StGameOver: begin
        game_over = 1'b1;
        if (start_btn && !start_prev_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Guard counter: how long wave_rst has been low, saturating at 2.
    low_d   = wave_rst ? 2'd0 : ((low_q == 2'd2) ? 2'd2 : low_q + 2'd1);
    speed_d = (speed_sum > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : speed_sum[7:0];
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      spawn_q      <= 1'b0;
      frame_q      <= '0;
      low_q        <= 2'd0;
      hit_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      score_q      <= '0;
      lives_q      <= 4'(START_LIVES);
      level_q      <= 4'd0;
      speed_q      <= 8'(BASE_SPEED);
    end else begin
      state_q      <= state_d;
      spawn_q      <= spawn_d;
      frame_q      <= frame_d;
      low_q        <= low_d;
      hit_prev_q   <= alien_hit;
      start_prev_q <= start_btn;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      speed_q      <= speed_d;
    end
  end

  assign speed = speed_q;
  assign score = score_q;
  assign lives = lives_q;
  assign level = level_q;

endmodule

// File: tb/tb_wave_controller.sv
// Directed bench for wave_controller: spawn timing, scoring, clear/death pauses, game over.
module tb_wave_controller;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b0;
  logic        fsync = 1'b0;
  logic        start_btn = 1'b0;
  logic        alien_hit = 1'b0;
  logic [5:0]  aliens_remaining = 6'd40;
  logic        alien_reached = 1'b0;
  logic        player_hit = 1'b0;
  logic [7:0]  speed;
  logic        wave_rst;
  logic        play_en;
  logic [15:0] score;
  logic [3:0]  lives;
  logic [3:0]  level;
  logic        game_over;

  int passed = 0;
  int total  = 0;

  wave_controller dut (
    .pixel_clk        (pixel_clk),
    .rst              (rst),
    .fsync            (fsync),
    .start_btn        (start_btn),
    .alien_hit        (alien_hit),
    .aliens_remaining (aliens_remaining),
    .alien_reached    (alien_reached),
    .player_hit       (player_hit),
    .speed            (speed),
    .wave_rst         (wave_rst),
    .play_en          (play_en),
    .score            (score),
    .lives            (lives),
    .level            (level),
    .game_over        (game_over)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame_pulse();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    ticks(3);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    ticks(2);
    chk("rst_wave_rst", 32'(wave_rst), 32'd1);
    chk("rst_play_en", 32'(play_en), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_speed", 32'(speed), 32'd1);
    rst = 1'b1;
    tick();

    // Start: two spawn cycles then PLAY
    start_btn = 1'b1;
    tick();
    chk("spawn1_wave_rst", 32'(wave_rst), 32'd1);
    chk("spawn1_play_en", 32'(play_en), 32'd0);
    start_btn = 1'b0;
    tick();
    chk("spawn2_wave_rst", 32'(wave_rst), 32'd1);
    tick();
    chk("play_wave_rst", 32'(wave_rst), 32'd0);
    chk("play_en", 32'(play_en), 32'd1);
    chk("play_speed", 32'(speed), 32'd1);
    chk("play_lives", 32'(lives), 32'd3);
    chk("play_score", 32'(score), 32'd0);

    // Held alien_hit scores once per rising edge
    alien_hit = 1'b1;
    ticks(5);
    chk("score_first_kill", 32'(score), 32'd10);
    alien_hit = 1'b0;
    ticks(2);
    for (int k = 0; k < 2; k++) begin
      alien_hit = 1'b1;
      ticks(5);
      alien_hit = 1'b0;
      ticks(2);
    end
    chk("score_three_kills", 32'(score), 32'd30);

    // start_btn in PLAY is ignored
    start_btn = 1'b1;
    tick();
    chk("start_in_play", 32'(play_en), 32'd1);
    start_btn = 1'b0;

    // Wave clear: 120 frames paused, then level 1
    aliens_remaining = 6'd0;
    tick();
    chk("clear_play_en", 32'(play_en), 32'd0);
    aliens_remaining = 6'd40;
    for (int f = 0; f < 119; f++) frame_pulse();
    chk("clear_119_play_en", 32'(play_en), 32'd0);
    chk("clear_119_wave_rst", 32'(wave_rst), 32'd0);
    chk("clear_119_level", 32'(level), 32'd0);
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    chk("clear_done_wave_rst", 32'(wave_rst), 32'd1);
    chk("clear_done_level", 32'(level), 32'd1);
    tick();
    chk("clear_spawn2_wave_rst", 32'(wave_rst), 32'd1);
    chk("level1_speed", 32'(speed), 32'd2);
    tick();
    chk("wave2_play_en", 32'(play_en), 32'd1);

    // Player hit with a simultaneous kill: life lost, kill still scores
    player_hit = 1'b1;
    alien_hit  = 1'b1;
    tick();
    player_hit = 1'b0;
    alien_hit  = 1'b0;
    chk("death_lives", 32'(lives), 32'd2);
    chk("death_score", 32'(score), 32'd40);
    chk("death_play_en", 32'(play_en), 32'd0);
    for (int f = 0; f < 59; f++) frame_pulse();
    chk("death_59_wave_rst", 32'(wave_rst), 32'd0);
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    chk("death_done_wave_rst", 32'(wave_rst), 32'd1);
    ticks(2);
    chk("respawn_play_en", 32'(play_en), 32'd1);
    chk("respawn_level", 32'(level), 32'd1);
    chk("respawn_score", 32'(score), 32'd40);
    chk("respawn_lives", 32'(lives), 32'd2);

    // Remaining-count speed bonus (level 1, base speed 2)
    aliens_remaining = 6'd20;
    ticks(2);
`ifdef SPEEDUP_EN
    chk("bonus_half_speed", 32'(speed), 32'd3);
`else
    chk("bonus_half_speed", 32'(speed), 32'd2);
`endif
    aliens_remaining = 6'd10;
    ticks(2);
`ifdef SPEEDUP_EN
    chk("bonus_quarter_speed", 32'(speed), 32'd4);
`else
    chk("bonus_quarter_speed", 32'(speed), 32'd2);
`endif
    aliens_remaining = 6'd40;
    ticks(2);
    chk("bonus_gone_speed", 32'(speed), 32'd2);

    // Player hit and alien reached together: game over, lives zero
    player_hit    = 1'b1;
    alien_reached = 1'b1;
    tick();
    player_hit    = 1'b0;
    alien_reached = 1'b0;
    chk("go_lives", 32'(lives), 32'd0);
    chk("go_game_over", 32'(game_over), 32'd1);
    chk("go_wave_rst", 32'(wave_rst), 32'd0);
    chk("go_play_en", 32'(play_en), 32'd0);
    tick();
    chk("go_hold", 32'(game_over), 32'd1);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("idle_game_over", 32'(game_over), 32'd0);
    chk("idle_wave_rst", 32'(wave_rst), 32'd1);
    tick();
    chk("idle_hold_play_en", 32'(play_en), 32'd0);
    chk("idle_keeps_score", 32'(score), 32'd40);

    // New game reloads score/lives/level
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("newgame_score", 32'(score), 32'd0);
    chk("newgame_lives", 32'(lives), 32'd3);
    chk("newgame_level", 32'(level), 32'd0);
    ticks(2);
    chk("newgame_play_en", 32'(play_en), 32'd1);
    chk("newgame_speed", 32'(speed), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
